// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Ops, FSM state codes, iteration count and the divide-by-zero result.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef logic [1:0] md_state_t;

    localparam md_state_t StIdle = 2'd0;
    localparam md_state_t StCalc = 2'd1;
    localparam md_state_t StFix  = 2'd2;

    localparam int unsigned MD_ITER       = 32;
    localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFF_FFFF;

    // Two's-complement magnitude; 0x8000_0000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Accumulator is {upper, lower}; for divide that is {remainder, quotient}.
module md_step (
    input  logic        is_div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] operand_i,
    output logic [63:0] acc_o
);

    logic [32:0] add_sum;
    logic [32:0] shl_rem;
    logic [32:0] sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);
        // Remainder shifted left with the next dividend bit; 33 bits so the
        // subtraction borrow lands in bit 32.
        shl_rem  = acc_i[63:31];
        sub_diff = shl_rem - {1'b0, operand_i};
        if (is_div_i) begin
            if (!sub_diff[32]) begin
                acc_o = {sub_diff[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {shl_rem[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; fixed 33-cycle latency.
// Magnitudes are iterated unsigned; signs are applied in a single FIX cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_val_i,
    input  logic [WIDTH-1:0] rt_val_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_t        state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      opnd_q, opnd_d;
    logic [63:0]      acc_q, acc_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divzero_q, divzero_d;
    logic [31:0]      rs_q, rs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic        start_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    md_step u_step (
        .is_div_i  (op_q[1]),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    always_comb begin
        start_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        rs_mag       = start_signed ? md_abs(rs_val_i) : rs_val_i;
        rt_mag       = start_signed ? md_abs(rt_val_i) : rt_val_i;
    end

    // Sign correction for the FIX cycle; neg_* flags are only set for signed ops.
    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (!op_q[1]) begin
            fix_hi = prod_fix[63:32];
            fix_lo = prod_fix[31:0];
        end else if (divzero_q) begin
            fix_hi = rs_q;
            fix_lo = MD_DIVZERO_LO;
        end else begin
            fix_hi = rem_fix;
            fix_lo = quot_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divzero_d = divzero_q;
        rs_d      = rs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (start_i) begin
                    state_d   = StCalc;
                    cnt_d     = '0;
                    op_d      = op_i;
                    neg_res_d = start_signed && (rs_val_i[31] ^ rt_val_i[31]);
                    neg_rem_d = start_signed && rs_val_i[31];
                    divzero_d = (rt_val_i == '0);
                    rs_d      = rs_val_i;
                    if (op_i[1]) begin
                        acc_d  = {32'd0, rs_mag};
                        opnd_d = rt_mag;
                    end else begin
                        acc_d  = {32'd0, rt_mag};
                        opnd_d = rs_mag;
                    end
                end
            end
            StCalc: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MD_ITER - 1)) state_d = StFix;
            end
            StFix: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_q      <= MD_MULT;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divzero_q <= 1'b0;
            rs_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divzero_q <= divzero_d;
            rs_q      <= rs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference of HI/LO.
module tb_md_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_val_i;
    logic [31:0] rt_val_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    md_unit #(.WIDTH(32)) u_dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs_val_i (rs_val_i),
        .rt_val_i (rt_val_i),
        .hi_we_i  (hi_we_i),
        .lo_we_i  (lo_we_i),
        .wdata_i  (wdata_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} from MIPS arithmetic rules.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint p;
        int     sa;
        int     sb;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge in IDLE (or in a done cycle); returns at the negedge after FIX.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit wr_hi);
        logic [63:0] exp;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        int          n;
        bit          unstable;
        exp      = ref_md(op, a, b);
        start_i  = 1'b1;
        op_i     = op;
        rs_val_i = a;
        rt_val_i = b;
        if (wr_hi) begin
            hi_we_i = 1'b1;
            wdata_i = 32'h5A5A_0F0F;
        end
        @(negedge clk_i);
        start_i = 1'b0;
        hi_we_i = 1'b0;
        if (wr_hi) check("mthi_with_start", hi_o, 64'h5A5A_0F0F);
        hold_hi  = hi_o;
        hold_lo  = lo_o;
        n        = 0;
        unstable = 1'b0;
        while (busy_o && n < 100) begin
            n++;
            if (hi_o !== hold_hi || lo_o !== hold_lo || done_o) unstable = 1'b1;
            if (disturb && n == 5) begin
                start_i  = 1'b1;
                op_i     = 2'($urandom);
                rs_val_i = $urandom;
                rt_val_i = $urandom;
                lo_we_i  = 1'b1;
                wdata_i  = $urandom;
            end else if (disturb && n == 6) begin
                start_i = 1'b0;
                lo_we_i = 1'b0;
            end
            @(negedge clk_i);
        end
        check("busy_cycles", 64'(n), 64'd33);
        check("done_pulse", {63'd0, done_o}, 64'd1);
        check("hilo_hold", {63'd0, unstable}, 64'd0);
        check("hi", {32'd0, hi_o}, {32'd0, exp[63:32]});
        check("lo", {32'd0, lo_o}, {32'd0, exp[31:0]});
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          saw_done;

        rst_ni   = 1'b0;
        start_i  = 1'b0;
        op_i     = 2'd0;
        rs_val_i = '0;
        rt_val_i = '0;
        hi_we_i  = 1'b0;
        lo_we_i  = 1'b0;
        wdata_i  = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk_i);
        check("done_width", {63'd0, done_o}, 64'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        check("mult_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf_const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        run_op(2'd3, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check("divu_zero_const", {hi_o, lo_o}, 64'h0000_1234_FFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        @(negedge clk_i);
        lo_we_i = 1'b1;
        wdata_i = 32'hA5A5_A5A5;
        @(negedge clk_i);
        lo_we_i = 1'b0;
        check("mtlo", {32'd0, lo_o}, 64'hA5A5_A5A5);
        hi_we_i = 1'b1;
        wdata_i = 32'h1357_9BDF;
        @(negedge clk_i);
        hi_we_i = 1'b0;
        check("mthi", {hi_o, lo_o}, 64'h1357_9BDF_A5A5_A5A5);

        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b1);

        // Reset around iteration 10 aborts silently and clears HI/LO.
        start_i  = 1'b1;
        op_i     = 2'd1;
        rs_val_i = 32'hDEAD_BEEF;
        rt_val_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_hilo", {hi_o, lo_o}, 64'd0);
        check("abort_done", {63'd0, done_o}, 64'd0);
        rst_ni   = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        check("abort_quiet", {63'd0, saw_done}, 64'd0);

        // Back-to-back random ops, each started in the previous done cycle.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rop, ra, rb, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
